// File: rtl/otter_pipe_pkg.sv
// Shared pipeline types for the OTTER core: scoreboard entry, forwarding encoding, opcodes.
package otter_pipe_pkg;

  localparam int RD_MAX_W = 8;
  localparam int FWD_RF   = 0;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                is_load;
  } sb_entry_t;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

endpackage

// File: rtl/otter_fwd_match.sv
// Youngest-match priority encoder for one source operand against the scoreboard.
module otter_fwd_match #(
  parameter int DEPTH = 3,
  parameter int RA_W  = 5,
  parameter int SEL_W = $clog2(DEPTH+1)
) (
  input  logic                       used,
  input  logic [RA_W-1:0]            addr,
  input  logic [DEPTH:1]             ent_valid,
  input  logic [DEPTH:1]             ent_load,
  input  logic [DEPTH:1][RA_W-1:0]   ent_rd,
  output logic [SEL_W-1:0]           sel,
  output logic                       hit_load
);

  // Scan oldest to youngest so the lowest matching index is what remains.
  always_comb begin
    sel      = '0;
    hit_load = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (used && addr != '0 && ent_valid[k] && ent_rd[k] == addr) begin
        sel      = SEL_W'(k);
        hit_load = ent_load[k];
      end
    end
  end

endmodule

// File: rtl/otter_hazard_unit.sv
// Hazard/forwarding controller: scoreboard of in-flight rd, operand forwarding, load-use stall, redirect flush.
// Optional OTTER_HAZARD_STATS_EN adds saturating stall/flush counters.
module otter_hazard_unit
  import otter_pipe_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_AVAIL = 2,
  parameter int RA_W       = 5,
  parameter int SEL_W      = $clog2(DEPTH+1)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             de_valid,
  input  logic [RA_W-1:0]  de_rs1_addr,
  input  logic             de_rs1_used,
  input  logic [RA_W-1:0]  de_rs2_addr,
  input  logic             de_rs2_used,
  input  logic [RA_W-1:0]  de_rd_addr,
  input  logic             de_rd_used,
  input  logic             de_is_load,
  input  logic             ex_redirect,
  output logic             pc_write,
  output logic             if_de_hold,
  output logic             flush_de,
  output logic             bubble_ex,
  output logic [SEL_W-1:0] fwd_sel_a,
  output logic [SEL_W-1:0] fwd_sel_b
`ifdef OTTER_HAZARD_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
`endif
);

  localparam int NUM_OPS = 2;

  sb_entry_t sb [DEPTH:1];

  logic [DEPTH:1]                ent_valid, ent_load;
  logic [DEPTH:1][RA_W-1:0]      ent_rd;
  logic [NUM_OPS-1:0]            op_used, op_ld, load_use;
  logic [NUM_OPS-1:0][RA_W-1:0]  op_addr;
  logic [NUM_OPS-1:0][SEL_W-1:0] op_sel;
  logic                          stall, insert;

  genvar g;
  generate
    for (g = 1; g <= DEPTH; g++) begin : g_flat
      assign ent_valid[g] = sb[g].valid;
      assign ent_load[g]  = sb[g].is_load;
      assign ent_rd[g]    = RA_W'(sb[g].rd);
    end
  endgenerate

  assign op_used = {de_valid && de_rs2_used, de_valid && de_rs1_used};
  assign op_addr = {de_rs2_addr, de_rs1_addr};

  generate
    for (g = 0; g < NUM_OPS; g++) begin : g_op
      otter_fwd_match #(.DEPTH(DEPTH), .RA_W(RA_W), .SEL_W(SEL_W)) u_match (
        .used      (op_used[g]),
        .addr      (op_addr[g]),
        .ent_valid (ent_valid),
        .ent_load  (ent_load),
        .ent_rd    (ent_rd),
        .sel       (op_sel[g]),
        .hit_load  (op_ld[g])
      );
      assign load_use[g] = op_ld[g] && (int'(op_sel[g]) < LOAD_AVAIL);
    end
  endgenerate

  // Outputs are gated by RESET_N so an asserted reset takes effect within the cycle.
  assign stall      = RESET_N && de_valid && (|load_use) && !ex_redirect;
  assign pc_write   = !stall;
  assign if_de_hold = stall;
  assign flush_de   = RESET_N && ex_redirect;
  assign bubble_ex  = stall || (RESET_N && ex_redirect);
  assign fwd_sel_a  = (RESET_N && !stall) ? op_sel[0] : SEL_W'(FWD_RF);
  assign fwd_sel_b  = (RESET_N && !stall) ? op_sel[1] : SEL_W'(FWD_RF);

  assign insert = de_valid && de_rd_used && de_rd_addr != '0 && !stall && !ex_redirect;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 1; k <= DEPTH; k++) sb[k] <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) sb[k] <= sb[k-1];
      sb[1] <= insert ? '{valid: 1'b1, rd: RD_MAX_W'(de_rd_addr), is_load: de_is_load} : '0;
    end
  end

`ifdef OTTER_HAZARD_STATS_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF)       stall_cnt <= stall_cnt + 16'd1;
      if (ex_redirect && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_otter_hazard_unit.sv
// Directed bench for otter_hazard_unit (DEPTH=3, LOAD_AVAIL=2); covers stats counters when OTTER_HAZARD_STATS_EN is set.
module tb_otter_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       de_valid, de_rs1_used, de_rs2_used, de_rd_used, de_is_load, ex_redirect;
  logic [4:0] de_rs1_addr, de_rs2_addr, de_rd_addr;
  logic       pc_write, if_de_hold, flush_de, bubble_ex;
  logic [1:0] fwd_sel_a, fwd_sel_b;
`ifdef OTTER_HAZARD_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  otter_hazard_unit #(.DEPTH(3), .LOAD_AVAIL(2), .RA_W(5), .SEL_W(2)) dut (
    .CLK(clk), .RESET_N(rst_n),
    .de_valid(de_valid),
    .de_rs1_addr(de_rs1_addr), .de_rs1_used(de_rs1_used),
    .de_rs2_addr(de_rs2_addr), .de_rs2_used(de_rs2_used),
    .de_rd_addr(de_rd_addr), .de_rd_used(de_rd_used),
    .de_is_load(de_is_load), .ex_redirect(ex_redirect),
    .pc_write(pc_write), .if_de_hold(if_de_hold), .flush_de(flush_de), .bubble_ex(bubble_ex),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b)
`ifdef OTTER_HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // {pc_write, if_de_hold, flush_de, bubble_ex, fwd_sel_a, fwd_sel_b}
  function automatic logic [7:0] outv();
    return {pc_write, if_de_hold, flush_de, bubble_ex, fwd_sel_a, fwd_sel_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_de(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic ud, input logic ld);
    de_valid = v;  de_rs1_addr = rs1; de_rs1_used = u1;
    de_rs2_addr = rs2; de_rs2_used = u2;
    de_rd_addr = rd; de_rd_used = ud; de_is_load = ld;
  endtask

  task automatic drain();
    set_de(0, 0, 0, 0, 0, 0, 0, 0);
    ex_redirect = 0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    ex_redirect = 0;
    set_de(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
    #2;
    tests++;
    if (outv() !== 8'b1000_00_00) begin fails++; $display("FAIL reset_outputs got=%b exp=%b", outv(), 8'b1000_00_00); end
    #10 rst_n = 1;
    drain();
  endtask

  task automatic test_fwd_alu();
    set_de(1, 5'd2, 1, 5'd3, 1, 5'd1, 1, 0);                 // add x1,x2,x3
    #1; tests++;
    if (outv() !== 8'b1000_00_00) begin fails++; $display("FAIL alu_first got=%b exp=%b", outv(), 8'b1000_00_00); end
    tick();
    set_de(1, 5'd1, 1, 5'd5, 1, 5'd4, 1, 0);                 // add x4,x1,x5
    #1; tests++;
    if (outv() !== 8'b1000_01_00) begin fails++; $display("FAIL alu_fwd_ex got=%b exp=%b", outv(), 8'b1000_01_00); end
    tick();
    set_de(1, 5'd1, 1, 5'd0, 1, 5'd6, 1, 0);                 // add x6,x1,x0
    #1; tests++;
    if (outv() !== 8'b1000_10_00) begin fails++; $display("FAIL alu_fwd_mem got=%b exp=%b", outv(), 8'b1000_10_00); end
    tick();
    set_de(1, 5'd1, 1, 5'd4, 1, 5'd7, 1, 0);                 // x1 in WB, x4 in MEM
    #1; tests++;
    if (outv() !== 8'b1000_11_10) begin fails++; $display("FAIL alu_fwd_wb got=%b exp=%b", outv(), 8'b1000_11_10); end
    drain();
  endtask

  task automatic test_x0();
    set_de(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 0);                 // addi x0,x1,1
    #1; tests++;
    if (outv() !== 8'b1000_00_00) begin fails++; $display("FAIL x0_writer got=%b exp=%b", outv(), 8'b1000_00_00); end
    tick();
    set_de(1, 5'd0, 1, 5'd0, 1, 5'd2, 1, 0);                 // add x2,x0,x0
    #1; tests++;
    if (outv() !== 8'b1000_00_00) begin fails++; $display("FAIL x0_reader got=%b exp=%b", outv(), 8'b1000_00_00); end
    drain();
  endtask

  task automatic test_youngest();
    set_de(1, 5'd0, 1, 5'd0, 0, 5'd3, 1, 0);                 // addi x3,x0,1
    tick();
    set_de(1, 5'd0, 1, 5'd0, 0, 5'd3, 1, 0);                 // addi x3,x0,2
    #1; tests++;
    if (outv() !== 8'b1000_00_00) begin fails++; $display("FAIL young_mid got=%b exp=%b", outv(), 8'b1000_00_00); end
    tick();
    set_de(1, 5'd3, 1, 5'd0, 1, 5'd4, 1, 0);                 // add x4,x3,x0
    #1; tests++;
    if (outv() !== 8'b1000_01_00) begin fails++; $display("FAIL young_wins got=%b exp=%b", outv(), 8'b1000_01_00); end
    drain();
  endtask

  task automatic test_load_use();
    set_de(1, 5'd6, 1, 5'd0, 0, 5'd5, 1, 1);                 // lw x5,0(x6)
    tick();
    set_de(0, 5'd5, 1, 5'd5, 1, 5'd7, 1, 0);                 // invalid decode never stalls
    #1; tests++;
    if (outv() !== 8'b1000_00_00) begin fails++; $display("FAIL load_devalid0 got=%b exp=%b", outv(), 8'b1000_00_00); end
    set_de(1, 5'd5, 1, 5'd5, 1, 5'd7, 1, 0);                 // add x7,x5,x5
    #1; tests++;
    if (outv() !== 8'b0101_00_00) begin fails++; $display("FAIL load_stall got=%b exp=%b", outv(), 8'b0101_00_00); end
    tick();
    tests++;
    if (outv() !== 8'b1000_10_10) begin fails++; $display("FAIL load_after got=%b exp=%b", outv(), 8'b1000_10_10); end
    tick();
    set_de(1, 5'd7, 1, 5'd5, 1, 5'd8, 1, 0);                 // x7 in EX, x5 in WB
    #1; tests++;
    if (outv() !== 8'b1000_01_11) begin fails++; $display("FAIL load_bubble got=%b exp=%b", outv(), 8'b1000_01_11); end
    drain();
  endtask

  task automatic test_redirect();
    set_de(1, 5'd6, 1, 5'd0, 0, 5'd5, 1, 1);                 // lw x5
    tick();
    set_de(1, 5'd5, 1, 5'd5, 1, 5'd7, 1, 0);
    ex_redirect = 1;
    #1; tests++;
    if (outv() >> 4 !== 8'b1011) begin fails++; $display("FAIL redir_wins got=%b exp=1011", outv() >> 4); end
    tick();
    ex_redirect = 0;
    set_de(1, 5'd7, 1, 5'd5, 1, 5'd8, 1, 0);                 // squashed x7 absent, load now in MEM
    #1; tests++;
    if (outv() !== 8'b1000_00_10) begin fails++; $display("FAIL redir_after got=%b exp=%b", outv(), 8'b1000_00_10); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    set_de(1, 5'd6, 1, 5'd0, 0, 5'd5, 1, 1);
    tick();
    set_de(1, 5'd5, 1, 5'd0, 0, 5'd7, 1, 0);
    #1; tests++;
    if (outv() !== 8'b0101_00_00) begin fails++; $display("FAIL rst_pre_stall got=%b exp=%b", outv(), 8'b0101_00_00); end
    rst_n = 0;
    #1; tests++;
    if (outv() !== 8'b1000_00_00) begin fails++; $display("FAIL rst_in_stall got=%b exp=%b", outv(), 8'b1000_00_00); end
    #1 rst_n = 1;
    #1; tests++;
    if (outv() !== 8'b1000_00_00) begin fails++; $display("FAIL rst_cleared got=%b exp=%b", outv(), 8'b1000_00_00); end
    drain();
  endtask

`ifdef OTTER_HAZARD_STATS_EN
  task automatic test_stats();
    rst_n = 0; #1 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      set_de(1, 5'd6, 1, 5'd0, 0, 5'd5, 1, 1);
      tick();
      set_de(1, 5'd5, 1, 5'd0, 0, 5'd7, 1, 0);
      tick();
    end
    set_de(0, 0, 0, 0, 0, 0, 0, 0);
    ex_redirect = 1;
    repeat (2) tick();
    ex_redirect = 0;
    tests++;
    if (stall_cnt !== 16'd3) begin fails++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
    tests++;
    if (flush_cnt !== 16'd2) begin fails++; $display("FAIL flush_cnt got=%0d exp=2", flush_cnt); end
    rst_n = 0;
    #1; tests++;
    if ({stall_cnt, flush_cnt} !== 32'd0) begin fails++; $display("FAIL cnt_reset got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    #1 rst_n = 1;
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_fwd_alu();
    test_x0();
    test_youngest();
    test_load_use();
    test_redirect();
    test_reset_mid_stall();
`ifdef OTTER_HAZARD_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
